div_ctrl: RTL and testbench

Issue/sequencing controller for the iterative 32-bit radix-2 divider in the EX stage. It accepts DIV/DIVU from EX, drives the divider's start/annul handshake, and holds operands and op stable for the whole operation. It stalls the pipeline until the quotient/remainder is ready, then writes HI/LO exactly once. On pipeline flush it kills the operation and drains the divider back to free.

---
 rtl/div_ctrl_pkg.sv | 19 +
 rtl/div_ctrl.sv | 101 ++++++++++
 tb/tb_div_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared op codes and FSM encoding for the EX-stage divider issue controller.
package div_ctrl_pkg;

  localparam logic [5:0] DIV_CONTROL  = 6'b011010;
  localparam logic [5:0] DIVU_CONTROL = 6'b011011;

  typedef enum logic [2:0] {
    DIV_CTRL_IDLE   = 3'd0,
    DIV_CTRL_BUSY   = 3'd1,
    DIV_CTRL_DRAIN0 = 3'd2,
    DIV_CTRL_DRAIN1 = 3'd3,
    DIV_CTRL_DONE   = 3'd4
  } div_ctrl_state_e;

  function automatic logic is_div_op(input logic [5:0] op);
    return (op == DIV_CONTROL) || (op == DIVU_CONTROL);
  endfunction

endpackage

// File: rtl/div_ctrl.sv
// Issues DIV/DIVU to the iterative divider, stalls EX until the result is in,
// writes HI/LO once, and drains the divider back to free on a flush.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [5:0]  ex_op,
  input  logic [31:0] ex_opdata1,
  input  logic [31:0] ex_opdata2,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic [5:0]  div_op_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  div_ctrl_state_e state, state_nxt;
  logic            req;
  logic            issue;
  logic            capture;

  assign req = ex_valid && is_div_op(ex_op);

  always_comb begin
    state_nxt   = state;
    issue       = 1'b0;
    capture     = 1'b0;
    stall_o     = 1'b0;
    div_annul_o = flush_i;
    hilo_we_o   = 1'b0;
    unique case (state)
      DIV_CTRL_IDLE: begin
        if (req && !flush_i) begin
          issue     = 1'b1;
          stall_o   = 1'b1;
          state_nxt = DIV_CTRL_BUSY;
        end
      end
      DIV_CTRL_BUSY: begin
        stall_o = 1'b1;
        // A flush must win over a same-cycle ready so no stale write escapes.
        if (flush_i) begin
          state_nxt = DIV_CTRL_DRAIN0;
        end else if (div_ready_i) begin
          capture   = 1'b1;
          state_nxt = DIV_CTRL_DONE;
        end
      end
      DIV_CTRL_DONE: begin
        hilo_we_o = !flush_i;
        state_nxt = DIV_CTRL_IDLE;
      end
      DIV_CTRL_DRAIN0: begin
        stall_o     = 1'b1;
        div_annul_o = 1'b1;
        state_nxt   = DIV_CTRL_DRAIN1;
      end
      DIV_CTRL_DRAIN1: begin
        stall_o     = 1'b1;
        div_annul_o = 1'b1;
        state_nxt   = DIV_CTRL_IDLE;
      end
      default: state_nxt = DIV_CTRL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= DIV_CTRL_IDLE;
      div_start_o   <= 1'b0;
      div_op_o      <= '0;
      div_opdata1_o <= '0;
      div_opdata2_o <= '0;
      hi_o          <= '0;
      lo_o          <= '0;
    end else begin
      state       <= state_nxt;
      // Start is high for exactly the BUSY cycles, so it drops in DONE/DRAIN.
      div_start_o <= (state_nxt == DIV_CTRL_BUSY);
      if (issue) begin
        div_op_o      <= ex_op;
        div_opdata1_o <= ex_opdata1;
        div_opdata2_o <= ex_opdata2;
      end
      if (capture) begin
        hi_o <= div_result_i[63:32];
        lo_o <= div_result_i[31:0];
      end
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl; the bench plays the divider, driving ready/result
// on the cycle the real radix-2 divider would.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [5:0]  ex_op;
  logic [31:0] ex_opdata1, ex_opdata2;
  logic        flush_i;
  logic        stall_o, div_start_o, div_annul_o;
  logic [5:0]  div_op_o;
  logic [31:0] div_opdata1_o, div_opdata2_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        hilo_we_o;
  logic [31:0] hi_o, lo_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  div_ctrl dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_opdata1(ex_opdata1), .ex_opdata2(ex_opdata2), .flush_i(flush_i),
    .stall_o(stall_o), .div_start_o(div_start_o), .div_annul_o(div_annul_o),
    .div_op_o(div_op_o), .div_opdata1_o(div_opdata1_o), .div_opdata2_o(div_opdata2_o),
    .div_result_i(div_result_i), .div_ready_i(div_ready_i), .hilo_we_o(hilo_we_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded, got no summary, required finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Request in the current IDLE cycle, return inside B0.
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    ex_valid = 1'b1; ex_op = op; ex_opdata1 = a; ex_opdata2 = b;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    #1;
    total_cnt++;
    if ({stall_o, div_start_o, hilo_we_o, div_annul_o} !== 4'b0000)
      $display("FAIL reset_ctl: got %b required 0000", {stall_o, div_start_o, hilo_we_o, div_annul_o});
    else pass_cnt++;
    total_cnt++;
    if ({div_op_o, div_opdata1_o, div_opdata2_o, hi_o, lo_o} !== '0)
      $display("FAIL reset_data: got op=%h d1=%h d2=%h hi=%h lo=%h required all 0",
               div_op_o, div_opdata1_o, div_opdata2_o, hi_o, lo_o);
    else pass_cnt++;
    rst = 1'b1;
    step();
  endtask

  // Full issue-to-write of one division; ends in the IDLE cycle after DONE.
  task automatic test_divide(input string name, input logic [5:0] op,
                             input logic [31:0] a, input logic [31:0] b, input int lat,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int bad;
    ex_valid = 1'b1; ex_op = op; ex_opdata1 = a; ex_opdata2 = b;
    #1;
    total_cnt++;
    if ({stall_o, div_start_o} !== 2'b10)
      $display("FAIL %s req_cycle: stall/start got %b required 10", name, {stall_o, div_start_o});
    else pass_cnt++;
    step();
    total_cnt++;
    if ({div_start_o, stall_o, div_op_o, div_opdata1_o, div_opdata2_o} !== {2'b11, op, a, b})
      $display("FAIL %s b0_latch: start=%b stall=%b op=%h d1=%h d2=%h required 1 1 %h %h %h",
               name, div_start_o, stall_o, div_op_o, div_opdata1_o, div_opdata2_o, op, a, b);
    else pass_cnt++;
    ex_opdata1 = ~a; ex_opdata2 = ~b;
    bad = 0;
    for (int k = 1; k < lat; k++) begin
      step();
      if ({stall_o, div_start_o, hilo_we_o, div_annul_o} !== 4'b1100 ||
          div_opdata1_o !== a || div_opdata2_o !== b || div_op_o !== op) bad++;
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL %s busy_hold: %0d bad cycles required 0", name, bad);
    else pass_cnt++;
    step();
    div_ready_i = 1'b1; div_result_i = {exp_hi, exp_lo};
    #1;
    total_cnt++;
    if ({stall_o, hilo_we_o} !== 2'b10)
      $display("FAIL %s ready_cycle: stall/we got %b required 10", name, {stall_o, hilo_we_o});
    else pass_cnt++;
    step();
    div_ready_i = 1'b0; div_result_i = '0;
    #1;
    total_cnt++;
    if ({hilo_we_o, stall_o, div_start_o, div_annul_o} !== 4'b1000)
      $display("FAIL %s done_ctl: we/stall/start/annul got %b required 1000", name,
               {hilo_we_o, stall_o, div_start_o, div_annul_o});
    else pass_cnt++;
    total_cnt++;
    if ({hi_o, lo_o} !== {exp_hi, exp_lo})
      $display("FAIL %s result: hi=%h lo=%h required hi=%h lo=%h", name, hi_o, lo_o, exp_hi, exp_lo);
    else pass_cnt++;
    step();
    ex_valid = 1'b0;
    #1;
    total_cnt++;
    if ({hilo_we_o, stall_o, div_start_o} !== 3'b000)
      $display("FAIL %s after_done: we/stall/start got %b required 000", name,
               {hilo_we_o, stall_o, div_start_o});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    test_divide("divu_max", DIVU_CONTROL, 32'hFFFF_FFFF, 32'h0000_0010, 35, 32'h0000_000F, 32'h0FFF_FFFF);
    test_divide("div_100_7", DIV_CONTROL, 32'd100, 32'd7, 35, 32'd2, 32'd14);
  endtask

  task automatic test_flush_busy();
    issue(DIV_CONTROL, 32'd50, 32'd5);
    repeat (10) step();
    flush_i = 1'b1;
    #1;
    total_cnt++;
    if ({div_annul_o, stall_o} !== 2'b11)
      $display("FAIL flush_b10: annul/stall got %b required 11", {div_annul_o, stall_o});
    else pass_cnt++;
    step();
    flush_i = 1'b0; ex_valid = 1'b0;
    #1;
    total_cnt++;
    if ({div_annul_o, stall_o, div_start_o, hilo_we_o} !== 4'b1100)
      $display("FAIL flush_drain0: annul/stall/start/we got %b required 1100",
               {div_annul_o, stall_o, div_start_o, hilo_we_o});
    else pass_cnt++;
    step();
    total_cnt++;
    if ({div_annul_o, stall_o, div_start_o, hilo_we_o} !== 4'b1100)
      $display("FAIL flush_drain1: annul/stall/start/we got %b required 1100",
               {div_annul_o, stall_o, div_start_o, hilo_we_o});
    else pass_cnt++;
    step();
    total_cnt++;
    if ({div_annul_o, stall_o, div_start_o, hilo_we_o} !== 4'b0000)
      $display("FAIL flush_idle: annul/stall/start/we got %b required 0000",
               {div_annul_o, stall_o, div_start_o, hilo_we_o});
    else pass_cnt++;
    test_divide("divu_9_4", DIVU_CONTROL, 32'd9, 32'd4, 35, 32'd1, 32'd2);
  endtask

  task automatic test_flush_ready();
    int bad;
    issue(DIV_CONTROL, 32'd77, 32'd3);
    repeat (35) step();
    div_ready_i = 1'b1; div_result_i = {32'hDEAD_BEEF, 32'h1234_5678}; flush_i = 1'b1;
    #1;
    total_cnt++;
    if ({div_annul_o, hilo_we_o} !== 2'b10)
      $display("FAIL flush_ready_cyc: annul/we got %b required 10", {div_annul_o, hilo_we_o});
    else pass_cnt++;
    step();
    div_ready_i = 1'b0; div_result_i = '0; flush_i = 1'b0; ex_valid = 1'b0;
    bad = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      if ({div_annul_o, stall_o, hilo_we_o, div_start_o} !== 4'b1100) bad++;
      step();
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL flush_ready_drain: %0d bad cycles required 0", bad);
    else pass_cnt++;
    total_cnt++;
    if ({hi_o, lo_o, stall_o, hilo_we_o} !== {32'd1, 32'd2, 2'b00})
      $display("FAIL flush_ready_idle: hi=%h lo=%h stall=%b we=%b required 1 2 0 0",
               hi_o, lo_o, stall_o, hilo_we_o);
    else pass_cnt++;
  endtask

  task automatic test_flush_done();
    issue(DIV_CONTROL, 32'd21, 32'd4);
    repeat (34) step();
    step();
    div_ready_i = 1'b1; div_result_i = {32'd1, 32'd5};
    step();
    div_ready_i = 1'b0; div_result_i = '0; flush_i = 1'b1;
    #1;
    total_cnt++;
    if ({hilo_we_o, div_annul_o, stall_o, div_start_o} !== 4'b0100)
      $display("FAIL flush_done: we/annul/stall/start got %b required 0100",
               {hilo_we_o, div_annul_o, stall_o, div_start_o});
    else pass_cnt++;
    step();
    flush_i = 1'b0; ex_valid = 1'b0;
    #1;
    total_cnt++;
    if ({hilo_we_o, div_annul_o, stall_o, div_start_o} !== 4'b0000)
      $display("FAIL flush_done_idle: we/annul/stall/start got %b required 0000",
               {hilo_we_o, div_annul_o, stall_o, div_start_o});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_busy();
    issue(DIV_CONTROL, 32'd1000, 32'd9);
    repeat (20) step();
    rst = 1'b0; ex_valid = 1'b0;
    step();
    #1;
    total_cnt++;
    if ({stall_o, div_start_o, hilo_we_o, div_annul_o, div_op_o, div_opdata1_o,
         div_opdata2_o, hi_o, lo_o} !== '0)
      $display("FAIL reset_mid_busy: stall=%b start=%b we=%b annul=%b op=%h d1=%h d2=%h hi=%h lo=%h required all 0",
               stall_o, div_start_o, hilo_we_o, div_annul_o, div_op_o, div_opdata1_o,
               div_opdata2_o, hi_o, lo_o);
    else pass_cnt++;
    rst = 1'b1;
    step();
    test_divide("div_m8_3", DIV_CONTROL, 32'hFFFF_FFF8, 32'd3, 35, 32'hFFFF_FFFE, 32'hFFFF_FFFE);
  endtask

  initial begin
    rst = 1'b0; ex_valid = 1'b0; ex_op = '0; ex_opdata1 = '0; ex_opdata2 = '0;
    flush_i = 1'b0; div_result_i = '0; div_ready_i = 1'b0;
    test_reset();
    test_divide("div_7_m2", DIV_CONTROL, 32'd7, 32'hFFFF_FFFE, 35, 32'h0000_0001, 32'hFFFF_FFFD);
    step();
    test_back_to_back();
    step();
    test_divide("div_by_zero", DIV_CONTROL, 32'd123, 32'd0, 3, 32'd0, 32'd0);
    step();
    test_flush_busy();
    step();
    test_flush_ready();
    test_flush_done();
    step();
    test_reset_mid_busy();
    step();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
